i2c_rx_fifo: RTL and testbench

I2C_RX_FIFO -- requirements
Module: i2c_rx_fifo

---
 rtl/i2c_rx_fifo.sv | 103 ++++++++++
 tb/tb_i2c_rx_fifo.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/i2c_rx_fifo.sv
// Receive FIFO for an I2C slave: circular buffer with count, sticky error flags.
// Define I2C_RX_FIFO_FWFT_EN for first-word-fall-through reads; default is registered reads.
module i2c_rx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  rd_en,
    input  logic                  clr_flags,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                    DEPTH      = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE    = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

    logic [DATA_W-1:0]     r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_ovf_err;
    logic w_udf_err;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == FULL_COUNT);
    // A pop frees a slot in the same cycle, so a full FIFO can still take a push.
    assign w_pop     = rd_en && !w_empty;
    assign w_push    = wr_en && (!w_full || w_pop);
    assign w_ovf_err = wr_en && w_full && !w_pop;
    assign w_udf_err = rd_en && w_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            // A new error wins over a same-cycle clear.
            r_overflow  <= (r_overflow  && !clr_flags) || w_ovf_err;
            r_underflow <= (r_underflow && !clr_flags) || w_udf_err;
        end
    end

    // NOTE: storage is deliberately not reset; entries are only observable once written.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= wr_data;
    end

`ifdef I2C_RX_FIFO_FWFT_EN
    assign rd_data  = r_mem[r_rd_ptr];
    assign rd_valid = !w_empty;
`else
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_pop;
            if (w_pop) r_rd_data <= r_mem[r_rd_ptr];
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
`endif

    assign empty     = w_empty;
    assign full      = w_full;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_i2c_rx_fifo.sv
// Self-checking bench for i2c_rx_fifo (standard read mode) against a queue-based reference model.
module tb_i2c_rx_fifo;

    localparam int DEPTH_LOG2 = 4;
    localparam int DATA_W     = 8;
    localparam int DEPTH      = 2 ** DEPTH_LOG2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              wr_en = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              rd_en = 1'b0;
    logic              clr_flags = 1'b0;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              empty;
    logic              full;
    logic [DEPTH_LOG2:0] count;
    logic              overflow;
    logic              underflow;

    i2c_rx_fifo #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .DATA_W    (DATA_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .clr_flags(clr_flags),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: contents as an ordered queue plus expected output registers.
    logic [DATA_W-1:0] m_q[$];
    logic [DATA_W-1:0] m_rd_data  = '0;
    logic              m_rd_valid = 1'b0;
    logic              m_ovf      = 1'b0;
    logic              m_udf      = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic w, input logic [DATA_W-1:0] d, input logic r,
                        input logic c, input logic x, input string tag);
        int  sz;
        logic pop, push;
        @(negedge clk);
        wr_en = w; wr_data = d; rd_en = r; clr_flags = c; rst = x;
        sz = m_q.size();
        if (x) begin
            m_q.delete();
            m_rd_data  = '0;
            m_rd_valid = 1'b0;
            m_ovf      = 1'b0;
            m_udf      = 1'b0;
        end else begin
            pop  = r && (sz > 0);
            push = w && ((sz < DEPTH) || pop);
            m_ovf = (m_ovf && !c) || (w && (sz == DEPTH) && !pop);
            m_udf = (m_udf && !c) || (r && (sz == 0));
            m_rd_valid = pop;
            if (pop)  m_rd_data = m_q.pop_front();
            if (push) m_q.push_back(d);
        end
        @(posedge clk);
        #1;
        check({tag, ".rd_valid"},  32'(rd_valid),  32'(m_rd_valid));
        check({tag, ".rd_data"},   32'(rd_data),   32'(m_rd_data));
        check({tag, ".count"},     32'(count),     32'(m_q.size()));
        check({tag, ".empty"},     32'(empty),     32'(m_q.size() == 0));
        check({tag, ".full"},      32'(full),      32'(m_q.size() == DEPTH));
        check({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
        check({tag, ".underflow"}, 32'(underflow), 32'(m_udf));
    endtask

    initial begin
        // Reset state.
        step(1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, "reset");
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "reset2");

        // Two-byte push/pop with literal expectations on top of the model.
        step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, "push_a5");
        step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, "push_3c");
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "pop1");
        check("pop1.lit", 32'(rd_data), 32'hA5);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "pop2");
        check("pop2.lit", 32'(rd_data), 32'h3C);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "idle");
        check("idle.valid_pulse", 32'(rd_valid), 32'h0);
        check("idle.empty_lit", 32'(empty), 32'h1);

        // Fill to full, then overflow with the 17th byte.
        for (int i = 0; i < 17; i++)
            step(1'b1, DATA_W'(i), 1'b0, 1'b0, 1'b0, "fill");
        check("fill.full_lit", 32'(full), 32'h1);
        check("fill.ovf_lit", 32'(overflow), 32'h1);

        // Simultaneous push/pop at full: no new overflow, count holds.
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "clr");
        step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0, "full_rw");
        check("full_rw.count_lit", 32'(count), 32'd16);
        for (int i = 0; i < 16; i++)
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "drain");
        check("drain.last_lit", 32'(rd_data), 32'h77);

        // Underflow, then clear.
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "udf");
        check("udf.lit", 32'(underflow), 32'h1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "udf_clr");
        // Clear and new error in the same cycle leaves the flag set.
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, "clr_vs_err");
        // Push into empty with rd_en: not a pop.
        step(1'b1, 8'hC3, 1'b1, 1'b1, 1'b0, "push_empty_rd");
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, "pop_c3");

        // Interleaved traffic long enough to wrap the pointers twice.
        for (int i = 0; i < 20; i++) begin
            step(1'b1, DATA_W'($urandom), 1'b0, 1'b0, 1'b0, "il_push");
            step(1'b1, DATA_W'($urandom), 1'b1, 1'b0, 1'b0, "il_both");
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "il_pop");
        end
        while (m_q.size() > 0)
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "il_drain");

        // Reset with 5 entries stored, then a clean round trip.
        for (int i = 0; i < 5; i++)
            step(1'b1, DATA_W'($urandom), 1'b0, 1'b0, 1'b0, "pre_rst");
        step(1'b1, 8'h11, 1'b1, 1'b1, 1'b1, "mid_rst");
        check("mid_rst.count_lit", 32'(count), 32'h0);
        step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, "push_5a");
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "pop_5a");
        check("pop_5a.lit", 32'(rd_data), 32'h5A);

        // Randomised traffic with phases biased toward filling and draining.
        for (int i = 0; i < 600; i++) begin
            logic w, r, c, x;
            if ((i / 60) % 2 == 0) begin
                w = ($urandom_range(0, 3) != 0);
                r = ($urandom_range(0, 3) == 0);
            end else begin
                w = ($urandom_range(0, 3) == 0);
                r = ($urandom_range(0, 3) != 0);
            end
            c = ($urandom_range(0, 15) == 0);
            x = ($urandom_range(0, 127) == 0);
            step(w, DATA_W'($urandom), r, c, x, "rand");
        end

        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0; clr_flags = 1'b0; rst = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
